// File: rtl/vc_plane_scheduler_if.sv
// Switch-control plane selection bus between the VC request side and the
// plane scheduler.
interface vc_plane_scheduler_if #(
  parameter int VC      = 4,
  parameter int QUANTUM = 4
);
  localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

  logic [VC-1:0] vcRequest;
  logic          holdPlane;
  logic [VC:0]   VCPlaneSelector;
  logic          planeValid;
  logic          planeSwitch;
  logic [CW-1:0] quantumCount;

  modport master (
    output vcRequest, holdPlane,
    input  VCPlaneSelector, planeValid, planeSwitch, quantumCount
  );

  modport slave (
    input  vcRequest, holdPlane,
    output VCPlaneSelector, planeValid, planeSwitch, quantumCount
  );
endinterface

// File: rtl/vc_plane_scheduler.sv
// Round-robin, quantum-bounded time multiplexer of the switch-control path
// across VC planes; selector value VC means no plane is selected.
module vc_plane_scheduler #(
    parameter int VC      = 4,
    parameter int QUANTUM = 4
) (
    input logic clk,
    input logic rst,
    vc_plane_scheduler_if.slave bus
);
    localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam int PW = (VC > 1) ? $clog2(VC) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SERVE = 1'b1;

    localparam logic [CW-1:0] QMAX     = CW'(QUANTUM - 1);
    localparam logic [VC:0]   SEL_IDLE = (VC + 1)'(VC);

    function automatic logic [PW-1:0] nextOf(input logic [PW-1:0] p);
        if (int'(p) == VC - 1) return '0;
        return p + 1'b1;
    endfunction

    logic [0:0]    state;
    logic [VC:0]   sel;
    logic [PW-1:0] rrPtr;
    logic [CW-1:0] cnt;
    logic          sw;

    logic [PW-1:0] cur;
    logic [PW-1:0] pick;
    logic [VC-1:0] masked;
    logic          found;
    logic          expire;
    int            base;
    int            idx;

    assign cur    = sel[PW-1:0];
    assign expire = !bus.vcRequest[cur] || (cnt == QMAX);

    // Scan from the start point; walking offsets high-to-low lets the nearest
    // set bit win. The current plane is masked so it never re-wins its own slot.
    always_comb begin
        masked = bus.vcRequest;
        if (state == SERVE) masked[cur] = 1'b0;
        base  = (state == SERVE) ? int'(nextOf(cur)) : int'(rrPtr);
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = VC - 1; i >= 0; i--) begin
            idx = base + i;
            if (idx >= VC) idx = idx - VC;
            if (masked[PW'(idx)]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sel   <= SEL_IDLE;
            rrPtr <= '0;
            cnt   <= '0;
            sw    <= 1'b0;
        end else begin
            sw <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= SERVE;
                        sel   <= (VC + 1)'(pick);
                        cnt   <= '0;
                        sw    <= 1'b1;
                    end
                end
                SERVE: begin
                    if (bus.holdPlane) begin
                        // Mid-handshake: never move, just age the quantum.
                        if (cnt != QMAX) cnt <= cnt + 1'b1;
                    end else if (!expire) begin
                        cnt <= cnt + 1'b1;
                    end else if (found) begin
                        sel   <= (VC + 1)'(pick);
                        cnt   <= '0;
                        sw    <= 1'b1;
                        rrPtr <= nextOf(pick);
                    end else if (bus.vcRequest[cur]) begin
                        cnt <= '0;
                    end else begin
                        state <= IDLE;
                        sel   <= SEL_IDLE;
                        cnt   <= '0;
                        sw    <= 1'b1;
                        rrPtr <= nextOf(cur);
                    end
                end
                default: begin
                    state <= IDLE;
                    sel   <= SEL_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.VCPlaneSelector = sel;
    assign bus.planeValid      = (state == SERVE);
    assign bus.planeSwitch     = sw;
    assign bus.quantumCount    = cnt;
endmodule

// File: tb/tb_vc_plane_scheduler.sv
// Self-checking bench: per-cycle vector table through a scoreboard queue,
// plus hand sequences for reset, async reset mid-serve and QUANTUM=1.
module tb_vc_plane_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vc_plane_scheduler_if #(.VC(4), .QUANTUM(4)) bus  ();
    vc_plane_scheduler_if #(.VC(4), .QUANTUM(1)) bus1 ();

    vc_plane_scheduler #(.VC(4), .QUANTUM(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    vc_plane_scheduler #(.VC(4), .QUANTUM(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [3:0] req;
        logic       hold;
        logic [4:0] sel;
        logic       valid;
        logic       sw;
        logic [1:0] cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic h, input logic [4:0] s,
                       input logic w, input logic [1:0] c);
        vec_t v;
        v.req = r; v.hold = h; v.sel = s; v.valid = (s < 5'd4); v.sw = w; v.cnt = c;
        tbl.push_back(v);
    endtask

    initial begin
        vec_t e;
        bus.vcRequest  = 4'b1111;
        bus.holdPlane  = 1'b0;
        bus1.vcRequest = 4'b0000;
        bus1.holdPlane = 1'b0;

        // round-robin over all four planes, then wrap to 0
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 4; c++) add(4'hF, 1'b0, 5'(p), c == 0, 2'(c));
        for (int c = 0; c < 4; c++) add(4'hF, 1'b0, 5'd0, c == 0, 2'(c));
        add(4'hF, 1'b0, 5'd1, 1'b1, 2'd0);
        add(4'hF, 1'b0, 5'd1, 1'b0, 2'd1);
        // early release of plane 1 -> 3, then wrap to 0
        for (int c = 0; c < 4; c++) add(4'b1001, 1'b0, 5'd3, c == 0, 2'(c));
        add(4'b1001, 1'b0, 5'd0, 1'b1, 2'd0);
        for (int c = 1; c < 4; c++) add(4'hF, 1'b0, 5'd0, 1'b0, 2'(c));
        for (int c = 0; c < 4; c++) add(4'hF, 1'b0, 5'd1, c == 0, 2'(c));
        add(4'hF, 1'b0, 5'd2, 1'b1, 2'd0);
        // hold on plane 2 for 10 cycles: count saturates at 3
        for (int k = 0; k < 10; k++) add(4'hF, 1'b1, 5'd2, 1'b0, (k < 2) ? 2'(k + 1) : 2'd3);
        add(4'hF, 1'b0, 5'd3, 1'b1, 2'd0);
        // sole requester plane 2: no switch after entry
        add(4'b0100, 1'b0, 5'd2, 1'b1, 2'd0);
        for (int k = 1; k < 9; k++) add(4'b0100, 1'b0, 5'd2, 1'b0, 2'(k % 4));
        // drain from plane 1 to idle, then re-entry from rrPtr=2
        add(4'b0010, 1'b0, 5'd1, 1'b1, 2'd0);
        add(4'b0010, 1'b0, 5'd1, 1'b0, 2'd1);
        add(4'b0000, 1'b0, 5'd4, 1'b1, 2'd0);
        add(4'b0000, 1'b0, 5'd4, 1'b0, 2'd0);
        add(4'hF,    1'b0, 5'd2, 1'b1, 2'd0);
        add(4'hF,    1'b0, 5'd2, 1'b0, 2'd1);

        // reset held with all planes requesting
        #12;
        chk("reset sel",   32'(bus.VCPlaneSelector), 32'd4);
        chk("reset valid", 32'(bus.planeValid),      32'd0);
        chk("reset sw",    32'(bus.planeSwitch),     32'd0);
        chk("reset cnt",   32'(bus.quantumCount),    32'd0);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            bus.vcRequest = tbl[i].req;
            bus.holdPlane = tbl[i].hold;
            sbq.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            chk($sformatf("row%0d sel", i),   32'(bus.VCPlaneSelector), 32'(e.sel));
            chk($sformatf("row%0d valid", i), 32'(bus.planeValid),      32'(e.valid));
            chk($sformatf("row%0d sw", i),    32'(bus.planeSwitch),     32'(e.sw));
            chk($sformatf("row%0d cnt", i),   32'(bus.quantumCount),    32'(e.cnt));
        end
        chk("scoreboard drained", 32'(sbq.size()), 32'd0);

        // async reset mid-serve, no clock edge in between
        #2 rst = 1'b0;
        #1;
        chk("async sel",   32'(bus.VCPlaneSelector), 32'd4);
        chk("async valid", 32'(bus.planeValid),      32'd0);
        chk("async sw",    32'(bus.planeSwitch),     32'd0);
        chk("async cnt",   32'(bus.quantumCount),    32'd0);
        bus.vcRequest  = 4'b0000;
        bus1.vcRequest = 4'b1111;
        #2 rst = 1'b1;

        // QUANTUM=1: re-arbitrate every cycle unless held
        for (int k = 0; k < 8; k++) begin
            bus1.holdPlane = (k == 5 || k == 6);
            @(posedge clk);
            #1;
            chk($sformatf("q1 step%0d sel", k), 32'(bus1.VCPlaneSelector),
                (k < 5) ? 32'(k % 4) : (k < 7) ? 32'd0 : 32'd1);
            chk($sformatf("q1 step%0d sw", k), 32'(bus1.planeSwitch),
                (k == 5 || k == 6) ? 32'd0 : 32'd1);
            chk($sformatf("q1 step%0d cnt", k), 32'(bus1.quantumCount), 32'd0);
        end
        chk("q1 idle main sel", 32'(bus.VCPlaneSelector), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
